// File: rtl/filter_pkg.sv
// Shared constants for the luma 3x3 Gaussian filter: frame geometry,
// pipeline latency, kernel weights/rounding and line-memory bank offsets.
package filter_pkg;

  localparam int HAC        = 1920;
  localparam int VAC        = 1080;
  localparam int DATA_WIDTH = 8;
  localparam int ROW_W      = 11;

  localparam int FILTER_LAT = 4;

  // Kernel is separable 1-2-1; the centre tap is a left shift by one.
  localparam int W_CENTRE_SHIFT = 1;
  localparam int RND            = 8;
  localparam int SHIFT          = 4;

  localparam logic [1:0] BANK_BOT = 2'd1;
  localparam logic [1:0] BANK_MID = 2'd2;
  localparam logic [1:0] BANK_TOP = 2'd3;

endpackage

// File: rtl/filter_vsum.sv
// Selects the three most recent completed rows from the line memories,
// replicates the middle row at the top/bottom frame edges, and forms the 1-2-1 column sum.
module filter_vsum
  import filter_pkg::*;
#(
  parameter int DW       = filter_pkg::DATA_WIDTH,
  parameter int NB       = 4,
  parameter int VAC_ROWS = filter_pkg::VAC
) (
  input  logic [NB*DW-1:0] i_rdata,
  input  logic [1:0]       i_wr_bank,
  input  logic [ROW_W-1:0] i_row,
  output logic [DW+1:0]    o_vsum
);

  logic [1:0]    bot_bank;
  logic [1:0]    mid_bank;
  logic [1:0]    top_bank;
  logic [DW-1:0] top_px;
  logic [DW-1:0] mid_px;
  logic [DW-1:0] bot_px;

  // Two-bit subtraction gives the mod-4 wrap of the bank ring for free.
  assign bot_bank = i_wr_bank - BANK_BOT;
  assign mid_bank = i_wr_bank - BANK_MID;
  assign top_bank = i_wr_bank - BANK_TOP;

  always_comb begin
    mid_px = i_rdata[mid_bank*DW +: DW];
    top_px = i_rdata[top_bank*DW +: DW];
    bot_px = i_rdata[bot_bank*DW +: DW];
    if (i_row == '0) begin
      top_px = mid_px;
    end
    if (i_row == ROW_W'(VAC_ROWS - 1)) begin
      bot_px = mid_px;
    end
    o_vsum = {2'b00, top_px} + ({2'b00, mid_px} << W_CENTRE_SHIFT) + {2'b00, bot_px};
  end

endmodule

// File: rtl/filter_gauss3x3.sv
// Luma 3x3 Gaussian stage: column sum, 3-tap horizontal window with edge
// replication, rounding, and a matching 4-cycle delay on vs/hs/de.
module filter_gauss3x3
  import filter_pkg::*;
#(
  parameter int DATA_WIDTH = filter_pkg::DATA_WIDTH,
  parameter int NUM_BANK   = 4,
  parameter int HAC        = filter_pkg::HAC,
  parameter int VAC        = filter_pkg::VAC
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_vs,
  input  logic                           i_hs,
  input  logic                           i_de,
  input  logic [1:0]                     i_wr_bank,
  input  logic [NUM_BANK*DATA_WIDTH-1:0] i_mem_y_rdata,
  output logic [DATA_WIDTH-1:0]          o_y,
  output logic                           o_vs,
  output logic                           o_hs,
  output logic                           o_de
);

  localparam int VW = DATA_WIDTH + 2;
  localparam int HW = DATA_WIDTH + 4;

  if (NUM_BANK != 4 || HAC < 1 || VAC < 1 || VAC > (1 << ROW_W)) begin : g_cfg_check
    $error("filter_gauss3x3: unsupported configuration");
  end

  logic                    armed_q, armed_d;
  logic                    de_eff;
  logic [FILTER_LAT-1:0]   de_q, de_d;
  logic [FILTER_LAT-1:0]   hs_q, hs_d;
  logic [FILTER_LAT-1:0]   vs_q, vs_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [VW-1:0]           vsum_q, vsum_d;
  logic [VW-1:0]           v1_q, v1_d;
  logic [VW-1:0]           v2_q, v2_d;
  logic [VW-1:0]           left_col;
  logic [VW-1:0]           right_col;
  logic [HW-1:0]           hsum_q, hsum_d;
  logic [DATA_WIDTH-1:0]   y_q, y_d;

  filter_vsum #(
    .DW      (DATA_WIDTH),
    .NB      (NUM_BANK),
    .VAC_ROWS(VAC)
  ) u_vsum (
    .i_rdata  (i_mem_y_rdata),
    .i_wr_bank(i_wr_bank),
    .i_row    (row_q),
    .o_vsum   (vsum_d)
  );

  // After reset, a line already in progress is ignored until de has been seen low.
  // de_q[0..3] hold the enable aligned with vsum_q, v1_q (centre), hsum_q and y_q.
  always_comb begin
    armed_d = armed_q | ~i_de;
    de_eff  = i_de & armed_q;
    de_d    = {de_q[FILTER_LAT-2:0], de_eff};
    hs_d    = {hs_q[FILTER_LAT-2:0], i_hs};
    vs_d    = {vs_q[FILTER_LAT-2:0], i_vs};

    row_d = row_q;
    if (i_vs) begin
      row_d = '0;
    end else if (de_q[0] && !de_eff && row_q != ROW_W'(VAC - 1)) begin
      row_d = row_q + ROW_W'(1);
    end

    // vsum_q is the newest column (v0); v1_q is the centre, v2_q the left.
    v1_d = vsum_q;
    v2_d = v1_q;
    left_col  = (de_q[1] && !de_q[2]) ? v1_q : v2_q;
    right_col = (de_q[1] && !de_q[0]) ? v1_q : vsum_q;
    hsum_d = HW'(left_col) + (HW'(v1_q) << W_CENTRE_SHIFT) + HW'(right_col);

    y_d = '0;
    if (de_q[2]) begin
      y_d = DATA_WIDTH'((hsum_q + HW'(RND)) >> SHIFT);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed_q <= 1'b0;
      de_q    <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
      row_q   <= '0;
      vsum_q  <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      hsum_q  <= '0;
      y_q     <= '0;
    end else begin
      armed_q <= armed_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      row_q   <= row_d;
      vsum_q  <= vsum_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      hsum_q  <= hsum_d;
      y_q     <= y_d;
    end
  end

  assign o_y  = y_q;
  assign o_de = de_q[FILTER_LAT-1];
  assign o_hs = hs_q[FILTER_LAT-1];
  assign o_vs = vs_q[FILTER_LAT-1];

endmodule
